// File: rtl/gelato_types.sv
// Shared types for the gelato fetch front end.
package gelato_types;

   localparam int GELATO_WARP_NUM        = 4;
   localparam int GELATO_ADDR_WIDTH      = 32;
   localparam int GELATO_SPLIT_IDX_WIDTH = 2;
   localparam int GELATO_WARP_IDX_WIDTH  = $clog2(GELATO_WARP_NUM);

   typedef logic [GELATO_WARP_IDX_WIDTH-1:0]  warp_idx_t;
   typedef logic [GELATO_ADDR_WIDTH-1:0]      pc_t;
   typedef logic [GELATO_SPLIT_IDX_WIDTH-1:0] split_idx_t;

   typedef struct packed {
      warp_idx_t  warp;
      pc_t        pc;
      split_idx_t split_num;
   } fetch_req_t;

   typedef enum logic {
      FS_IDLE = 1'b0,
      FS_HOLD = 1'b1
   } fetch_skd_state_e;

endpackage

// File: rtl/gelato_fetch_scheduler_if.sv
// Fetch request channel between the warp scheduler and the fetch stage.
interface gelato_fetch_scheduler_if
   import gelato_types::*;
#(
   parameter int ADDR_WIDTH      = GELATO_ADDR_WIDTH,
   parameter int SPLIT_IDX_WIDTH = GELATO_SPLIT_IDX_WIDTH,
   parameter int WARP_IDX_WIDTH  = GELATO_WARP_IDX_WIDTH
);
   logic                       fetch_valid;
   logic                       fetch_ready;
   logic [WARP_IDX_WIDTH-1:0]  fetch_warp;
   logic [ADDR_WIDTH-1:0]      fetch_pc;
   logic [SPLIT_IDX_WIDTH-1:0] fetch_split_num;

   modport master (
      output fetch_valid, fetch_warp, fetch_pc, fetch_split_num,
      input  fetch_ready
   );

   modport slave (
      input  fetch_valid, fetch_warp, fetch_pc, fetch_split_num,
      output fetch_ready
   );
endinterface

// File: rtl/gelato_rr_arbiter.sv
// Combinational round-robin arbiter: first set req bit at or after ptr,
// searching circularly. N must be a power of two so the index wraps for free.
module gelato_rr_arbiter #(
   parameter int  N = 4,
   localparam int W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic         gnt_valid,
   output logic [W-1:0] gnt_idx
);

   logic [W-1:0] idx;

   // circular priority scan starting at ptr
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      idx       = '0;
      for (int i = 0; i < N; i++) begin
         idx = ptr + W'(i);
         if (!gnt_valid && req[idx]) begin
            gnt_valid = 1'b1;
            gnt_idx   = idx;
         end
      end
   end

endmodule

// File: rtl/gelato_fetch_scheduler.sv
// Per-cycle warp fetch scheduler: picks one eligible warp round-robin, holds
// its request on a valid/ready channel, and blocks the warp until decode
// releases it so each warp has at most one instruction in flight.
//
// state   | meaning
// FS_IDLE | no request held, fetch_valid low
// FS_HOLD | request held in output register, fetch_valid high
module gelato_fetch_scheduler
   import gelato_types::*;
#(
   parameter int  WARP_NUM        = GELATO_WARP_NUM,
   parameter int  ADDR_WIDTH      = GELATO_ADDR_WIDTH,
   parameter int  SPLIT_IDX_WIDTH = GELATO_SPLIT_IDX_WIDTH,
   localparam int WARP_IDX_WIDTH  = $clog2(WARP_NUM)
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                rdy,
   input  logic [WARP_NUM-1:0]                 warp_valid,
   input  logic [WARP_NUM*ADDR_WIDTH-1:0]      warp_pc,
   input  logic [WARP_NUM*SPLIT_IDX_WIDTH-1:0] warp_split_num,
   gelato_fetch_scheduler_if.master            fetch,
   input  logic                                release_valid,
   input  logic [WARP_IDX_WIDTH-1:0]           release_warp,
   output logic [WARP_NUM-1:0]                 busy_mask,
   output logic                                err_release
);

   typedef struct packed {
      logic [WARP_IDX_WIDTH-1:0]  warp;
      logic [ADDR_WIDTH-1:0]      pc;
      logic [SPLIT_IDX_WIDTH-1:0] split_num;
   } req_t;

   fetch_skd_state_e            state_q, state_d;
   req_t                        req_q, req_d;
   logic [WARP_NUM-1:0]         busy_q, busy_d;
   logic [WARP_NUM-1:0]         held, elig;
   logic [WARP_IDX_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
   logic [WARP_IDX_WIDTH-1:0]   gnt_idx;
   logic                        gnt_valid;
   logic                        load;
   logic                        err_q, err_d;
   logic [ADDR_WIDTH-1:0]       pc_arr    [WARP_NUM];
   logic [SPLIT_IDX_WIDTH-1:0]  split_arr [WARP_NUM];

   // unpack flat per-warp buses
   always_comb begin
      for (int i = 0; i < WARP_NUM; i++) begin
         pc_arr[i]    = warp_pc[i*ADDR_WIDTH +: ADDR_WIDTH];
         split_arr[i] = warp_split_num[i*SPLIT_IDX_WIDTH +: SPLIT_IDX_WIDTH];
      end
   end

   // eligibility from registered busy bits; the held warp is excluded explicitly
   always_comb begin
      held = '0;
      for (int i = 0; i < WARP_NUM; i++) begin
         held[i] = (state_q == FS_HOLD) && (req_q.warp == WARP_IDX_WIDTH'(i));
      end
      elig = warp_valid & ~busy_q & ~held;
   end

   gelato_rr_arbiter #(.N(WARP_NUM)) u_arb (
      .req       (elig),
      .ptr       (rr_ptr_q),
      .gnt_valid (gnt_valid),
      .gnt_idx   (gnt_idx)
   );

   // next state; load means a new grant enters the output register
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      case (state_q)
         FS_IDLE: begin
            if (gnt_valid) begin
               load    = 1'b1;
               state_d = FS_HOLD;
            end
         end
         FS_HOLD: begin
            if (fetch.fetch_ready) begin
               if (gnt_valid) load = 1'b1;
               else           state_d = FS_IDLE;
            end
         end
         default: state_d = FS_IDLE;
      endcase
   end

   // request/pointer/busy/error next values; a grant sets busy after any release clears
   always_comb begin
      req_d    = req_q;
      rr_ptr_d = rr_ptr_q;
      busy_d   = busy_q;
      err_d    = err_q;
      if (release_valid) begin
         if (!busy_q[release_warp]) err_d = 1'b1;
         busy_d[release_warp] = 1'b0;
      end
      if (load) begin
         req_d.warp      = gnt_idx;
         req_d.pc        = pc_arr[gnt_idx];
         req_d.split_num = split_arr[gnt_idx];
         rr_ptr_d        = gnt_idx + 1'b1;
         busy_d[gnt_idx] = 1'b1;
      end
   end

   // state registers; rdy low freezes everything
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= FS_IDLE;
         req_q    <= '0;
         rr_ptr_q <= '0;
         busy_q   <= '0;
         err_q    <= 1'b0;
      end else if (rdy) begin
         state_q  <= state_d;
         req_q    <= req_d;
         rr_ptr_q <= rr_ptr_d;
         busy_q   <= busy_d;
         err_q    <= err_d;
      end
   end

   assign fetch.fetch_valid     = (state_q == FS_HOLD);
   assign fetch.fetch_warp      = req_q.warp;
   assign fetch.fetch_pc        = req_q.pc;
   assign fetch.fetch_split_num = req_q.split_num;
   assign busy_mask             = busy_q;
   assign err_release           = err_q;

endmodule

// File: tb/tb_gelato_fetch_scheduler.sv
// Directed bench for gelato_fetch_scheduler with an expected-grant scoreboard.
module tb_gelato_fetch_scheduler;
   import gelato_types::*;

   localparam int WN = 4;
   localparam int AW = 32;
   localparam int SW = 2;
   localparam int WW = 2;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            rdy = 1'b1;
   logic [WN-1:0]   warp_valid = '0;
   logic [WN*AW-1:0] warp_pc;
   logic [WN*SW-1:0] warp_split_num;
   logic            release_valid = 1'b0;
   logic [WW-1:0]   release_warp = '0;
   logic [WN-1:0]   busy_mask;
   logic            err_release;

   int vectors = 0;
   int miscompares = 0;
   fetch_req_t sb[$];

   gelato_fetch_scheduler_if fif ();

   gelato_fetch_scheduler dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .rdy            (rdy),
      .warp_valid     (warp_valid),
      .warp_pc        (warp_pc),
      .warp_split_num (warp_split_num),
      .fetch          (fif),
      .release_valid  (release_valid),
      .release_warp   (release_warp),
      .busy_mask      (busy_mask),
      .err_release    (err_release)
   );

   always #5 clk = ~clk;

   function automatic logic [AW-1:0] base_pc(input int w);
      return 32'h1000 + AW'(w * 16);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int w, input logic [AW-1:0] pc);
      fetch_req_t e;
      e.warp      = WW'(w);
      e.pc        = pc;
      e.split_num = SW'(w);
      sb.push_back(e);
   endtask

   // one clock: scoreboard any handshake about to complete, then step past the edge
   task automatic tick();
      fetch_req_t e;
      @(negedge clk);
      if (fif.fetch_valid && fif.fetch_ready && rdy) begin
         vectors++;
         assert (sb.size() != 0) else begin
            miscompares++;
            $error("FAIL sb_unexpected: observed grant warp %0d expected none", fif.fetch_warp);
         end
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("sb_warp", 64'(fif.fetch_warp), 64'(e.warp));
            chk("sb_pc", 64'(fif.fetch_pc), 64'(e.pc));
            chk("sb_split", 64'(fif.fetch_split_num), 64'(e.split_num));
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int max_cycles);
      for (int i = 0; i < max_cycles && sb.size() != 0; i++) tick();
      chk("sb_drain_left", 64'(sb.size()), 64'd0);
   endtask

   task automatic release_w(input int w);
      release_valid = 1'b1;
      release_warp  = WW'(w);
      tick();
      release_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      sb.delete();
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < WN; i++) begin
         warp_pc[i*AW +: AW]        = base_pc(i);
         warp_split_num[i*SW +: SW] = SW'(i);
      end
      fif.fetch_ready = 1'b0;

      // reset values
      #12;
      chk("rst_fetch_valid", 64'(fif.fetch_valid), 64'd0);
      chk("rst_fetch_warp", 64'(fif.fetch_warp), 64'd0);
      chk("rst_fetch_pc", 64'(fif.fetch_pc), 64'd0);
      chk("rst_fetch_split", 64'(fif.fetch_split_num), 64'd0);
      chk("rst_busy", 64'(busy_mask), 64'd0);
      chk("rst_err", 64'(err_release), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // basic issue: warps 0 then 2
      warp_valid = 4'b0101;
      fif.fetch_ready = 1'b1;
      push(0, base_pc(0));
      push(2, base_pc(2));
      drain(8);
      chk("basic_idle_valid", 64'(fif.fetch_valid), 64'd0);
      chk("basic_busy", 64'(busy_mask), 64'b0101);
      warp_valid = 4'b0000;
      release_w(0);
      release_w(2);
      chk("basic_busy_cleared", 64'(busy_mask), 64'd0);
      chk("basic_err", 64'(err_release), 64'd0);

      // backpressure: request sampled at grant, held through stall
      warp_pc[1*AW +: AW] = 32'h100;
      fif.fetch_ready = 1'b0;
      warp_valid = 4'b0010;
      push(1, 32'h100);
      tick();
      chk("bp_grant_valid", 64'(fif.fetch_valid), 64'd1);
      chk("bp_grant_warp", 64'(fif.fetch_warp), 64'd1);
      for (int i = 0; i < 5; i++) begin
         if (i == 2) warp_pc[1*AW +: AW] = 32'h200;
         tick();
         chk("bp_stall_valid", 64'(fif.fetch_valid), 64'd1);
         chk("bp_stall_pc", 64'(fif.fetch_pc), 64'h100);
      end
      fif.fetch_ready = 1'b1;
      tick();
      chk("bp_hs_first_ready", 64'(sb.size()), 64'd0);
      chk("bp_after_valid", 64'(fif.fetch_valid), 64'd0);
      chk("bp_after_busy", 64'(busy_mask), 64'b0010);
      warp_valid = 4'b0000;
      release_w(1);
      warp_pc[1*AW +: AW] = base_pc(1);

      // round robin with release two cycles after each handshake
      do_reset();
      warp_valid = 4'b1111;
      fif.fetch_ready = 1'b1;
      push(0, base_pc(0));
      push(1, base_pc(1));
      push(2, base_pc(2));
      push(3, base_pc(3));
      push(0, base_pc(0));
      push(1, base_pc(1));
      tick();
      chk("rr_busy_c1", 64'(busy_mask), 64'b0001);
      tick();
      chk("rr_busy_c2", 64'(busy_mask), 64'b0011);
      tick();
      chk("rr_busy_c3", 64'(busy_mask), 64'b0111);
      release_valid = 1'b1;
      release_warp = 2'd0;
      tick();
      chk("rr_busy_c4", 64'(busy_mask), 64'b1110);
      release_warp = 2'd1;
      tick();
      chk("rr_busy_c5", 64'(busy_mask), 64'b1101);
      release_warp = 2'd2;
      tick();
      chk("rr_busy_c6", 64'(busy_mask), 64'b1011);
      warp_valid = 4'b0000;
      release_warp = 2'd3;
      tick();
      chk("rr_busy_c7", 64'(busy_mask), 64'b0011);
      release_valid = 1'b0;
      drain(4);
      chk("rr_end_valid", 64'(fif.fetch_valid), 64'd0);
      release_w(0);
      release_w(1);
      chk("rr_busy_cleared", 64'(busy_mask), 64'd0);

      // release of warp 0 coincident with warp 3 handshake
      warp_valid = 4'b0001;
      push(0, base_pc(0));
      tick();
      tick();
      chk("sim_pre_valid", 64'(fif.fetch_valid), 64'd0);
      chk("sim_pre_busy", 64'(busy_mask), 64'b0001);
      warp_valid = 4'b1001;
      fif.fetch_ready = 1'b0;
      push(3, base_pc(3));
      tick();
      chk("sim_hold_warp", 64'(fif.fetch_warp), 64'd3);
      chk("sim_hold_busy", 64'(busy_mask), 64'b1001);
      tick();
      fif.fetch_ready = 1'b1;
      release_valid = 1'b1;
      release_warp = 2'd0;
      push(0, base_pc(0));
      tick();
      release_valid = 1'b0;
      chk("sim_edge_valid", 64'(fif.fetch_valid), 64'd0);
      chk("sim_edge_busy", 64'(busy_mask), 64'b1000);
      tick();
      chk("sim_regrant_valid", 64'(fif.fetch_valid), 64'd1);
      chk("sim_regrant_warp", 64'(fif.fetch_warp), 64'd0);
      chk("sim_regrant_busy", 64'(busy_mask), 64'b1001);
      drain(4);
      chk("sim_end_valid", 64'(fif.fetch_valid), 64'd0);
      warp_valid = 4'b0000;
      release_w(0);
      release_w(3);
      chk("sim_busy_cleared", 64'(busy_mask), 64'd0);

      // spurious release is sticky and harmless
      release_w(2);
      chk("spur_err", 64'(err_release), 64'd1);
      chk("spur_busy", 64'(busy_mask), 64'd0);
      tick();
      tick();
      chk("spur_err_sticky", 64'(err_release), 64'd1);

      // rdy low freezes state, then async reset mid-request
      warp_valid = 4'b0100;
      fif.fetch_ready = 1'b0;
      push(2, base_pc(2));
      tick();
      chk("frz_grant_warp", 64'(fif.fetch_warp), 64'd2);
      rdy = 1'b0;
      fif.fetch_ready = 1'b1;
      release_valid = 1'b1;
      release_warp = 2'd2;
      warp_valid = 4'b1111;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("frz_valid", 64'(fif.fetch_valid), 64'd1);
         chk("frz_warp", 64'(fif.fetch_warp), 64'd2);
         chk("frz_pc", 64'(fif.fetch_pc), 64'(base_pc(2)));
         chk("frz_busy", 64'(busy_mask), 64'b0100);
         chk("frz_err", 64'(err_release), 64'd1);
      end
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 64'(fif.fetch_valid), 64'd0);
      chk("arst_busy", 64'(busy_mask), 64'd0);
      chk("arst_err", 64'(err_release), 64'd0);
      chk("arst_pc", 64'(fif.fetch_pc), 64'd0);
      sb.delete();
      rdy = 1'b1;
      release_valid = 1'b0;
      warp_valid = 4'b0000;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/gelato_fetch_scheduler.md
Name: gelato_fetch_scheduler

Overview:
Per-cycle warp scheduler between the split tables and the instruction fetch stage. It takes each warp's current PC, valid flag and split-table index from the split-table PC interface and picks one eligible warp round-robin. It issues a single fetch request over a valid/ready handshake. The warp is then blocked until decode has written the warp's split-table update and releases it, so no warp has more than one instruction in flight.

Parameters:
WARP_NUM, 4, number of warps; must be a power of two, at least 2
ADDR_WIDTH, 32, PC width
SPLIT_IDX_WIDTH, 2, split-table entry index width
WARP_IDX_WIDTH, $clog2(WARP_NUM), warp index width (derived, not overridable)

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
rdy  in  1  global enable; when low, all state holds
warp_valid  in  WARP_NUM  warp i has a live PC in its split table
warp_pc  in  WARP_NUM*ADDR_WIDTH  per-warp PC; warp i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH]
warp_split_num  in  WARP_NUM*SPLIT_IDX_WIDTH  per-warp active split-table entry index
fetch_valid  out  1  fetch request valid
fetch_ready  in  1  fetch stage accepts the request
fetch_warp  out  WARP_IDX_WIDTH  warp of the request
fetch_pc  out  ADDR_WIDTH  PC to fetch
fetch_split_num  out  SPLIT_IDX_WIDTH  split-table entry to tag the request with
release_valid  in  1  decode has completed the split-table update for release_warp
release_warp  in  WARP_IDX_WIDTH  warp to unblock
busy_mask  out  WARP_NUM  per-warp in-flight bits (debug/perf)
err_release  out  1  sticky: a release arrived for a warp that was not busy

Behaviour:
- Reset values: fetch_valid=0, fetch_warp=0, fetch_pc=0, fetch_split_num=0, busy_mask=0, err_release=0, rr_ptr=0.
- Eligibility: elig[i] = warp_valid[i] & ~busy[i] & ~(fetch_valid & fetch_warp==i). Eligibility uses registered busy bits only.
- Selection: the first eligible warp, searching circularly from rr_ptr. After a grant to warp g, rr_ptr = (g+1) mod WARP_NUM, wrapping naturally at WARP_NUM-1 to 0.
- Two-state FSM:
  - IDLE (fetch_valid=0): if any warp is eligible and rdy=1, load the output register with the selected warp/PC/split_num, set busy[g], and go to HOLD. fetch_valid rises the next cycle, giving 1-cycle latency from eligibility.
  - HOLD (fetch_valid=1): outputs stay stable until fetch_ready. When fetch_valid & fetch_ready & rdy, the handshake completes.
    - If another warp is eligible in the same cycle, load it and stay in HOLD. This gives back-to-back issue with no bubble.
    - Otherwise clear fetch_valid and return to IDLE.
- The PC and split_num are sampled at grant. Later changes on warp_pc do not alter a held request.
- warp_valid falling for a held warp does not cancel the request; the fetch stage drops it by tag if needed.
- Release: when release_valid & rdy, clear busy[release_warp].
  - If that bit is already 0, set err_release; the release has no other effect.
  - A released warp becomes eligible in the following cycle.
  - Release and grant in the same cycle for different warps both take effect.
  - Release of the warp currently being granted cannot occur, because a granted warp is busy.
- rdy=0: no state changes. Handshake and release inputs are ignored, so sources must hold them until rdy=1. Outputs stay stable.
- Asynchronous reset mid-request: all outputs and state return to reset values immediately. The in-flight request is abandoned.
- Only one fetch request is ever outstanding in the output register. busy_mask popcount is unbounded up to WARP_NUM.

Decomposition:
- gelato_types package gets: typedefs warp_idx_t (WARP_IDX_WIDTH), pc_t (ADDR_WIDTH), split_idx_t; struct fetch_req_t {warp, pc, split_num}; enum fetch_skd_state_e {FS_IDLE, FS_HOLD}.
- Sub-module gelato_rr_arbiter (parameter N): inputs req[N], ptr; outputs gnt_valid, gnt_idx. Pure combinational; reused by later issue arbiters.

Test Plan:
- Basic issue: after reset, warp_valid=4'b0101, fetch_ready=1, no releases. Required: warp 0 issued, then warp 2, then fetch_valid=0 with busy_mask=4'b0101.
- Backpressure: fetch_ready=0 for 5 cycles with warp 1 held at pc=32'h100. Change warp_pc[1] to 32'h200 mid-stall. Required: fetch_pc stays 32'h100, valid stays high, and the handshake completes on the first ready cycle.
- Round-robin fairness: all four warps valid, release each warp 2 cycles after its issue. Required: grant order 0,1,2,3,0,1 with no warp issued twice before the others.
- Simultaneous events: release warp 0 in the same cycle as warp 3's handshake completes. Required: warp 0 is issued with fetch_valid high on the next cycle; busy bits are correct each cycle.
- Spurious release: release_warp=2 while busy[2]=0. Required: err_release=1 and sticky until reset; busy_mask unchanged.
- rdy and reset: hold rdy=0 with a pending release and handshake, and check that state is frozen. Then assert rst_n=0 in HOLD. Required: fetch_valid=0 and busy_mask=0 asynchronously.
